// File: rtl/cnn_pkg.sv
// Shared types and size helpers for the convolution datapath.
package cnn_pkg;

  localparam int PIXEL_WIDTH = 32;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  // Line-buffer depth: K-1 full rows, plus K pixels, plus room for the extra lanes of one beat.
  function automatic int buf_depth(input int k, input int ifm_size, input int lanes);
    return (k - 1) * ifm_size + k + lanes - 1;
  endfunction

  // Number of valid K x K windows produced by one square frame.
  function automatic int window_count(input int ifm_size, input int k, input int stride);
    int n;
    n = (ifm_size - k) / stride + 1;
    return n * n;
  endfunction

endpackage

// File: rtl/window_pos_counter.sv
// Raster-position tracker: row/col of each beat's lane-0 pixel, per-lane window-valid mask
// (edge and stride masking) and the end-of-frame pulse.
module window_pos_counter
  import cnn_pkg::*;
#(
  parameter int IFM_SIZE    = 32,
  parameter int KERNAL_SIZE = 5,
  parameter int LANES       = 2,
  parameter int STRIDE      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic [LANES-1:0] win_valid,
  output logic             frame_done
);

  localparam int K  = KERNAL_SIZE;
  localparam int CW = $clog2(IFM_SIZE + 1);

  logic [CW-1:0]    row;
  logic [CW-1:0]    col;
  logic [LANES-1:0] lane_mask;
  logic             last_beat;

  // A coordinate can be a window's bottom-right corner once a full K span lies behind it
  // and it sits on the stride grid anchored at K-1.
  function automatic logic on_grid(input int pos);
    return (pos >= K - 1) && (((pos - (K - 1)) % STRIDE) == 0);
  endfunction

  // Mask and end-of-frame flag for the beat currently being offered.
  always_comb begin
    last_beat = (int'(row) == IFM_SIZE - 1) && (int'(col) == IFM_SIZE - LANES);
    lane_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_mask[l] = on_grid(int'(row)) && on_grid(int'(col) + l);
    end
  end

  // Advance the raster position and register the per-beat pulses.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row        <= '0;
      col        <= '0;
      win_valid  <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      row        <= '0;
      col        <= '0;
      win_valid  <= '0;
      frame_done <= 1'b0;
    end else if (in_valid) begin
      win_valid  <= lane_mask;
      frame_done <= last_beat;
      if (int'(col) == IFM_SIZE - LANES) begin
        col <= '0;
        row <= (int'(row) == IFM_SIZE - 1) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(LANES);
      end
    end else begin
      win_valid  <= '0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding K x K window generator: a shift-register line buffer fed LANES pixels per beat,
// with every lane's window tapped straight off the buffer registers.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 32,
  parameter int KERNAL_SIZE = 5,
  parameter int LANES       = 2,
  parameter int STRIDE      = 1
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               clear,
  input  logic                                               in_valid,
  input  logic [LANES*DATA_WIDTH-1:0]                        in_data,
  output logic [LANES-1:0]                                   win_valid,
  output logic [LANES*KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0] win_data,
  output logic                                               frame_done
);

  localparam int K         = KERNAL_SIZE;
  localparam int BUF_DEPTH = buf_depth(K, IFM_SIZE, LANES);

  // Index 0 holds the newest pixel.
  logic [DATA_WIDTH-1:0] line_buf [BUF_DEPTH];

  // Shift the buffer by one beat; a concurrent clear drops the beat.
  // NOTE: the buffer is reset explicitly so win_data reads zero out of reset; this keeps it in flops, not RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        line_buf[i] <= '0;
      end
    end else if (in_valid && !clear) begin
      for (int i = BUF_DEPTH - 1; i >= LANES; i--) begin
        line_buf[i] <= line_buf[i-LANES];
      end
      for (int l = 0; l < LANES; l++) begin
        line_buf[LANES-1-l] <= in_data[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Tap wiring: lane l's window has lane l's pixel as its bottom-right corner.
  for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
    for (genvar r = 0; r < K; r++) begin : g_row
      for (genvar c = 0; c < K; c++) begin : g_col
        localparam int TAP = (LANES - 1 - lane) + (K - 1 - r) * IFM_SIZE + (K - 1 - c);
        localparam int ELEM = lane * K * K + r * K + c;
        assign win_data[ELEM*DATA_WIDTH +: DATA_WIDTH] = line_buf[TAP];
      end
    end
  end

  window_pos_counter #(
    .IFM_SIZE   (IFM_SIZE),
    .KERNAL_SIZE(KERNAL_SIZE),
    .LANES      (LANES),
    .STRIDE     (STRIDE)
  ) u_pos (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .win_valid (win_valid),
    .frame_done(frame_done)
  );

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a raster-stream model (pixel history + beat index) checks three
// configurations every cycle, plus hand-computed literal expectations at key beats.
module tb_conv_window_gen;
  import cnn_pkg::*;

  // Config A: 8x8, K=3, 2 lanes (stride 1 and stride 2 instances share the inputs).
  // Config B: 32x32, K=5, 1 lane.
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid_a = 1'b0;
  logic [63:0]  in_data_a = '0;
  logic [1:0]   win_valid_a, win_valid_s;
  logic [575:0] win_data_a, win_data_s;
  logic         frame_done_a, frame_done_s;
  logic         in_valid_b = 1'b0;
  logic [31:0]  in_data_b = '0;
  logic [0:0]   win_valid_b;
  logic [799:0] win_data_b;
  logic         frame_done_b;

  always #5 clk = ~clk;

  conv_window_gen #(.DATA_WIDTH(32), .IFM_SIZE(8), .KERNAL_SIZE(3), .LANES(2), .STRIDE(1)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid_a), .in_data(in_data_a),
    .win_valid(win_valid_a), .win_data(win_data_a), .frame_done(frame_done_a));

  conv_window_gen #(.DATA_WIDTH(32), .IFM_SIZE(8), .KERNAL_SIZE(3), .LANES(2), .STRIDE(2)) dut_s (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid_a), .in_data(in_data_a),
    .win_valid(win_valid_s), .win_data(win_data_s), .frame_done(frame_done_s));

  conv_window_gen #(.DATA_WIDTH(32), .IFM_SIZE(32), .KERNAL_SIZE(5), .LANES(1), .STRIDE(1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid_b), .in_data(in_data_b),
    .win_valid(win_valid_b), .win_data(win_data_b), .frame_done(frame_done_b));

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [799:0] act, input logic [799:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Valid rule straight from the raster position of beat 'beat' within a frame.
  function automatic bit lane_ok(input int beat, input int l, input int ifm, input int k,
                                 input int lanes, input int stride);
    int pos, rr, cc;
    pos = beat * lanes;
    rr  = pos / ifm;
    cc  = pos % ifm + l;
    return (rr >= k - 1) && (cc >= k - 1) && ((rr - k + 1) % stride == 0) && ((cc - k + 1) % stride == 0);
  endfunction

  function automatic logic [287:0] pack9(input int v[9]);
    logic [287:0] p;
    for (int i = 0; i < 9; i++) p[i*32 +: 32] = v[i];
    return p;
  endfunction

  // ---------------- model ----------------
  pixel_t       hist_a[$];
  pixel_t       hist_b[$];
  int           beat_a = 0;
  int           beat_b = 0;
  logic [1:0]   ev_a, ev_s;
  logic         ed_a;
  logic [575:0] ew_a;
  logic [0:0]   ev_b;
  logic         ed_b;
  logic [799:0] ew_b;

  // Window element (r,c) of a lane is the pixel (K-1-r) rows and (K-1-c) columns before it in
  // the accepted stream; anything before the last reset reads as zero.
  always @(posedge clk) begin
    if (reset) begin
      hist_a.delete(); hist_b.delete();
      beat_a = 0; beat_b = 0;
      ev_a = '0; ev_s = '0; ed_a = 1'b0; ew_a = '0;
      ev_b = '0; ed_b = 1'b0; ew_b = '0;
    end else if (clear) begin
      beat_a = 0; beat_b = 0;
      ev_a = '0; ev_s = '0; ed_a = 1'b0;
      ev_b = '0; ed_b = 1'b0;
    end else begin
      if (in_valid_a) begin
        for (int l = 0; l < 2; l++) hist_a.push_back(in_data_a[l*32 +: 32]);
        for (int l = 0; l < 2; l++) begin
          ev_a[l] = lane_ok(beat_a, l, 8, 3, 2, 1);
          ev_s[l] = lane_ok(beat_a, l, 8, 3, 2, 2);
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
              int idx;
              idx = hist_a.size() - 2 + l - (2 - r) * 8 - (2 - c);
              ew_a[(l*9 + r*3 + c)*32 +: 32] = (idx >= 0) ? hist_a[idx] : '0;
            end
        end
        ed_a   = (beat_a == 31);
        beat_a = (beat_a + 1) % 32;
      end else begin
        ev_a = '0; ev_s = '0; ed_a = 1'b0;
      end
      if (in_valid_b) begin
        hist_b.push_back(in_data_b);
        ev_b[0] = lane_ok(beat_b, 0, 32, 5, 1, 1);
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) begin
            int idx;
            idx = hist_b.size() - 1 - (4 - r) * 32 - (4 - c);
            ew_b[(r*5 + c)*32 +: 32] = (idx >= 0) ? hist_b[idx] : '0;
          end
        ed_b   = (beat_b == 1023);
        beat_b = (beat_b + 1) % 1024;
      end else begin
        ev_b = '0; ed_b = 1'b0;
      end
    end
  end

  // ---------------- compare ----------------
  int cnt_a = 0, cnt_s = 0, cnt_s1 = 0, cnt_b = 0, done_a = 0, done_b = 0;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("win_valid_a", win_valid_a, ev_a);
      check("win_valid_s2", win_valid_s, ev_s);
      check("frame_done_a", frame_done_a, ed_a);
      check("frame_done_s2", frame_done_s, ed_a);
      check("win_data_a", win_data_a, ew_a);
      check("win_data_s2", win_data_s, ew_a);
      check("win_valid_b", win_valid_b, ev_b);
      check("frame_done_b", frame_done_b, ed_b);
      check("win_data_b", win_data_b, ew_b);
      cnt_a  += $countones(win_valid_a);
      cnt_s  += $countones(win_valid_s);
      cnt_s1 += int'(win_valid_s[1]);
      cnt_b  += int'(win_valid_b[0]);
      done_a += int'(frame_done_a);
      done_b += int'(frame_done_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic beat_a_drv(input int p0, input int p1);
    #1;
    in_valid_a = 1'b1;
    in_data_a  = {p1[31:0], p0[31:0]};
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_counts();
    cnt_a = 0; cnt_s = 0; cnt_s1 = 0; cnt_b = 0; done_a = 0; done_b = 0;
  endtask

  task automatic apply_reset();
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset win_valid_a", win_valid_a, 2'b00);
    check("reset win_data_a", win_data_a, '0);
    check("reset frame_done_a", frame_done_a, 1'b0);
    check("reset win_data_b", win_data_b, '0);
    reset = 1'b0;
  endtask

  // One 8x8 frame of ramp pixels starting at 'base', with optional random idle gaps.
  task automatic frame_a(input int base, input int max_gap);
    for (int b = 0; b < 32; b++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      beat_a_drv(base + 2*b, base + 2*b + 1);
      if (b < 8) check("rows 0-1 masked", win_valid_a, 2'b00);
      if (b == 8) check("C=0 wrap masked", win_valid_a, 2'b00);
      if (b == 9) begin
        check("first valid", win_valid_a, 2'b11);
        check("stride2 at C=2", win_valid_s, 2'b01);
        check("lane0 window", win_data_a[287:0],
              pack9('{base+0, base+1, base+2, base+8, base+9, base+10, base+16, base+17, base+18}));
        check("lane1 window", win_data_a[575:288],
              pack9('{base+1, base+2, base+3, base+9, base+10, base+11, base+17, base+18, base+19}));
      end
      if (b == 30) check("no early frame_done", frame_done_a, 1'b0);
      if (b == 31) check("frame_done after beat 32", frame_done_a, 1'b1);
    end
    idle(1);
    check("frame_done single pulse", frame_done_a, 1'b0);
  endtask

  task automatic frame_totals(input string tag);
    check({tag, " count s1"}, cnt_a, 36);
    check({tag, " count vs window_count"}, cnt_a, window_count(8, 3, 1));
    check({tag, " count s2"}, cnt_s, 9);
    check({tag, " s2 lane1 never valid"}, cnt_s1, 0);
    check({tag, " frame_done pulses"}, done_a, 1);
  endtask

  initial begin
    apply_reset();
    idle(2);

    // Ramp frame, gapless.
    clear_counts();
    frame_a(0, 0);
    frame_totals("frame1");

    // Second frame back-to-back-ish with random gaps; old data never in valid windows.
    clear_counts();
    frame_a(1000, 2);
    frame_totals("frame2 gaps");

    // Partial frame, then clear with a coincident beat that must be dropped.
    for (int b = 0; b < 10; b++) beat_a_drv(2000 + 2*b, 2000 + 2*b + 1);
    #1;
    clear = 1'b1;
    in_valid_a = 1'b1;
    in_data_a = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid_a = 1'b0;
    check("clear kills valid", win_valid_a, 2'b00);
    check("clear drops beat", win_data_a[287:0],
          pack9('{2000, 2001, 2002, 2008, 2009, 2010, 2016, 2017, 2018}));
    clear_counts();
    frame_a(3000, 0);
    frame_totals("after clear");

    // Mid-frame reset, then a fresh frame.
    for (int b = 0; b < 13; b++) beat_a_drv(4000 + 2*b, 4000 + 2*b + 1);
    apply_reset();
    clear_counts();
    frame_a(5000, 1);
    frame_totals("after reset");

    // Single-lane 32x32, K=5 frame.
    clear_counts();
    for (int b = 0; b < 1024; b++) begin
      #1;
      in_valid_b = 1'b1;
      in_data_b  = b;
      @(posedge clk); #1;
      in_valid_b = 1'b0;
      if (b == 131) check("k5 C=3 masked", win_valid_b, 1'b0);
      if (b == 132) begin
        check("k5 first valid", win_valid_b, 1'b1);
        check("k5 top-left", win_data_b[0*32 +: 32], 32'd0);
        check("k5 top-right", win_data_b[4*32 +: 32], 32'd4);
        check("k5 centre", win_data_b[12*32 +: 32], 32'd66);
        check("k5 bottom-left", win_data_b[20*32 +: 32], 32'd128);
        check("k5 bottom-right", win_data_b[24*32 +: 32], 32'd132);
      end
    end
    idle(1);
    check("k5 count", cnt_b, 784);
    check("k5 count vs window_count", cnt_b, window_count(32, 5, 1));
    check("k5 frame_done pulses", done_b, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Parametrised sliding-window generator for the convolution datapath. It accepts an input feature map in raster order, `LANES` pixels per beat, and keeps a `(K-1)` rows + `K` pixels line buffer. Every accepted beat it presents up to `LANES` complete `K×K` windows with per-lane valid flags, applying stride and edge masking. It sits between the IFM memory reader and the MAC array, and supersedes the fixed 5×5, two-input window FIFO.

## Interface
- `DATA_WIDTH`, 32, pixel width in bits
- `IFM_SIZE`, 32, feature-map width and height (square); must be a multiple of `LANES`
- `KERNAL_SIZE`, 5, window edge K, ≥2
- `LANES`, 2, pixels accepted per beat and windows emitted per beat; ≥1
- `STRIDE`, 1, window stride, power of two, ≤ `IFM_SIZE - KERNAL_SIZE + 1`
- `BUF_DEPTH`, `(K-1)*IFM_SIZE + K + LANES - 1`, derived line-buffer depth in pixels
- `clk`, in, 1, clock
- `reset`, in, 1, asynchronous, active-high
- `clear`, in, 1, synchronous frame restart; zeroes counters and valids, keeps buffer contents
- `in_valid`, in, 1, beat qualifier; no backpressure
- `in_data`, in, `LANES*DATA_WIDTH`, lane l at `[l*DW +: DW]`; lane 0 is earliest in raster order
- `win_valid`, out, `LANES`, per-lane window-valid pulse
- `win_data`, out, `LANES*K*K*DATA_WIDTH`, lane l window at offset `l*K*K*DW`; element `e = r*K + c` (r=0 top row, c=0 left column) at `[e*DW +: DW]` within the lane
- `frame_done`, out, 1, one-cycle pulse after the last beat of a frame

## Operation
- Buffer: on an accepted beat, shift by `LANES`. Buffer index 0 holds the newest pixel. Lane l is written to index `LANES-1-l`.
- Window of lane l, element (r,c) = `buf[(LANES-1-l) + (K-1-r)*IFM_SIZE + (K-1-c)]`. Lane l's window has lane l's pixel as its bottom-right corner.
- Counters: `row` (0..IFM_SIZE-1) and `col` (0..IFM_SIZE-LANES, step LANES) give the position of the beat's lane-0 pixel. They advance per beat. `col` wraps to 0 and increments `row`. At the last beat, both wrap to 0 and `frame_done` pulses.
- Lane l is valid for a beat at (R,C) if all of these hold:
  - `R ≥ K-1`
  - `C+l ≥ K-1`
  - `(R-(K-1)) mod STRIDE = 0`
  - `(C+l-(K-1)) mod STRIDE = 0`
- Windows that span the column wrap, or draw on the previous frame, are therefore never flagged valid. The buffer is not flushed between frames.
- `clear` and `in_valid` in the same cycle: `clear` wins and the beat is dropped (buffer not shifted).
- `reset`: all buffer entries 0, counters 0, `win_valid` 0, `frame_done` 0. `win_data` therefore reads 0. Reset mid-frame abandons the frame.
- Per-frame valid window count = `((IFM_SIZE-K)/STRIDE + 1)^2`.

## Timing
- Latency 1: a beat accepted at edge t produces `win_valid`, `win_data` and `frame_done` valid after edge t. They are held until the next edge.
- `win_valid` and `frame_done` are single-cycle pulses. They deassert on the next edge without a beat, or follow the new beat's mask.
- `win_data` is driven directly from buffer registers. There is no output register stage, and it holds value while `in_valid` is low.
- Throughput: one beat per cycle, back-to-back, gaps allowed anywhere.

## Structure
- Shared package `cnn_pkg`: `pixel_t` typedef, a `buf_depth(K, IFM_SIZE, LANES)` function, and a `window_count` function used by the control FSM and the bench.
- Sub-module `window_pos_counter` holds the `row`/`col` counters, stride phase checks, per-lane valid mask and `frame_done`. The top level holds only the shift buffer and the tap wiring (generate loops over lane, r, c).

## Test plan
Default config for scenarios 1–5: `IFM_SIZE`=8, K=3, `LANES`=2, STRIDE=1, pixel value = raster index.
- Ramp frame, one beat per cycle:
  - First valid is after beat 9 (pixels 18,19), with `win_valid`=2'b11.
  - Lane 0 window = {0,1,2,8,9,10,16,17,18}.
  - Lane 1 window = {1,2,3,9,10,11,17,18,19}.
  - Exactly 36 valid windows in the frame.
- Beat at C=0, R≥2 -> lane 0 and lane 1 both invalid (wrap windows masked). Beat at C=2 -> both valid.
- Same ramp with STRIDE=2 -> only lane 0 ever valid, only on rows 2,4,6 at C=2,4,6; 9 windows total.
- Random `in_valid` gaps -> window contents and count identical to the gapless run; `frame_done` pulses once, exactly after beat 32.
- Two frames back-to-back:
  - No valid windows in frame 2 rows 0–1.
  - Frame 2 windows match frame 2 data only.
  - Mid-frame `reset` -> all outputs 0 next cycle, then a full new frame yields 36 windows.
- `LANES`=1, K=5, `IFM_SIZE`=32 -> window taps match the legacy 5×5 ordering (mirrored); 784 valid windows.
